// File: rtl/st_to_mm_wide_fifo.sv
// st_to_mm_wide_fifo
// Single-clock FIFO that bridges an Avalon-ST sample source to a 32-bit
// Avalon-MM slave. 64-bit samples are read as two words: an address-0 read
// pops the entry and returns the low word, and it also latches the high word.
// An address-1 read then returns that latched high word.
//
// Ports:
//   wrclock, reset              sole clock, synchronous active-high reset
//   avalonst_sink_data/valid    incoming sample and its valid
//   avalonst_sink_ready         sink ready (ready-latency 0)
//   avalonmm_slave_address      word address: 0 pop, 1 high latch, 2 status, 3 drops/control
//   avalonmm_slave_read/write   MM strobes
//   avalonmm_slave_writedata    control word (address 3: bit0 flush, bit1 clear)
//   avalonmm_slave_readdata     combinational read data, 0 when not reading
//   avalonmm_slave_waitrequest  stalls an address-0 read while the FIFO is empty
module st_to_mm_wide_fifo #(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned BACKPRESSURE = 1,
  parameter int unsigned LEVEL_W      = $clog2(DEPTH) + 1
) (
  input  logic                  wrclock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] avalonst_sink_data,
  input  logic                  avalonst_sink_valid,
  output logic                  avalonst_sink_ready,
  input  logic [1:0]            avalonmm_slave_address,
  input  logic                  avalonmm_slave_read,
  input  logic                  avalonmm_slave_write,
  input  logic [31:0]           avalonmm_slave_writedata,
  output logic [31:0]           avalonmm_slave_readdata,
  output logic                  avalonmm_slave_waitrequest
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [LEVEL_W-1:0]    level;
  logic [LEVEL_W-1:0]    level_next;
  logic                  ready_q;
  logic                  overflow;
  logic [31:0]           drop_count;
  logic [31:0]           hi_latch;

  logic                  empty;
  logic                  full;
  logic                  pop;
  logic                  push_ok;
  logic                  push;
  logic                  drop;
  logic                  flush;
  logic                  clr;
  logic [DATA_WIDTH-1:0] head;
  logic [31:0]           head_hi;
  logic                  unused_bits;

  assign empty = (level == '0);
  assign full  = (level == LEVEL_W'(DEPTH));
  assign head  = mem[rd_ptr];

  assign avalonmm_slave_waitrequest = avalonmm_slave_read & (avalonmm_slave_address == 2'd0) & empty;
  assign pop   = avalonmm_slave_read & (avalonmm_slave_address == 2'd0) & ~empty;
  assign flush = avalonmm_slave_write & (avalonmm_slave_address == 2'd3) & avalonmm_slave_writedata[0];
  assign clr   = avalonmm_slave_write & (avalonmm_slave_address == 2'd3) & avalonmm_slave_writedata[1];

  // Ingress policy: registered ready, or always-ready with drop-on-full
  // (a same-cycle pop makes room for the incoming sample).
  if (BACKPRESSURE != 0) begin : g_bp
    assign avalonst_sink_ready = ready_q;
    assign push_ok             = avalonst_sink_valid & ready_q;
    assign drop                = 1'b0;
  end else begin : g_drop
    assign avalonst_sink_ready = ~reset;
    assign push_ok             = avalonst_sink_valid & (~full | pop);
    assign drop                = avalonst_sink_valid & full & ~pop;
  end

  // A flush discards any sample arriving in the same cycle.
  assign push = push_ok & ~flush & ~reset;

  if (DATA_WIDTH == 64) begin : g_hi64
    assign head_hi = head[DATA_WIDTH-1:32];
  end else begin : g_hi32
    assign head_hi = '0;
  end

  assign unused_bits = ^{avalonmm_slave_writedata[31:2], ready_q};

  // Occupancy after this edge.
  always_comb begin
    level_next = level;
    if (flush) begin
      level_next = '0;
    end else if (push && !pop) begin
      level_next = level + LEVEL_W'(1);
    end else if (pop && !push) begin
      level_next = level - LEVEL_W'(1);
    end
  end

  // Sample storage.
  always_ff @(posedge wrclock) begin
    if (push) begin
      mem[wr_ptr] <= avalonst_sink_data;
    end
  end

  // Pointers, level, ready, high-word latch and drop bookkeeping.
  always_ff @(posedge wrclock) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      level      <= '0;
      ready_q    <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
      hi_latch   <= '0;
    end else begin
      level   <= level_next;
      ready_q <= (level_next < LEVEL_W'(DEPTH));
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (pop) begin
        hi_latch <= head_hi;
      end
      // Clear takes priority over a same-cycle drop.
      if (clr) begin
        overflow   <= 1'b0;
        drop_count <= '0;
      end else if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 32'hFFFF_FFFF) begin
          drop_count <= drop_count + 32'd1;
        end
      end
    end
  end

  // Zero-latency read mux.
  always_comb begin
    avalonmm_slave_readdata = '0;
    if (avalonmm_slave_read) begin
      case (avalonmm_slave_address)
        2'd0:    avalonmm_slave_readdata = empty ? 32'd0 : head[31:0];
        2'd1:    avalonmm_slave_readdata = hi_latch;
        2'd2:    avalonmm_slave_readdata = {13'd0, overflow, full, empty, 16'(level)};
        default: avalonmm_slave_readdata = drop_count;
      endcase
    end
  end

endmodule

// File: tb/tb_st_to_mm_wide_fifo.sv
// Bench for st_to_mm_wide_fifo: one backpressure instance (index 0) and one
// drop-on-full instance (index 1), both 64-bit x 16. A queue-based model is
// compared against both every cycle; directed sequences add literal checks.
module tb_st_to_mm_wide_fifo;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] s_data  [2];
  logic        s_valid [2];
  logic        s_ready [2];
  logic [1:0]  addr    [2];
  logic        rd      [2];
  logic        wr      [2];
  logic [31:0] wd      [2];
  logic [31:0] rdata   [2];
  logic        wreq    [2];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  st_to_mm_wide_fifo #(.DATA_WIDTH(64), .DEPTH(16), .BACKPRESSURE(1)) dut_bp (
    .wrclock                    (clk),
    .reset                      (reset),
    .avalonst_sink_data         (s_data[0]),
    .avalonst_sink_valid        (s_valid[0]),
    .avalonst_sink_ready        (s_ready[0]),
    .avalonmm_slave_address     (addr[0]),
    .avalonmm_slave_read        (rd[0]),
    .avalonmm_slave_write       (wr[0]),
    .avalonmm_slave_writedata   (wd[0]),
    .avalonmm_slave_readdata    (rdata[0]),
    .avalonmm_slave_waitrequest (wreq[0])
  );

  st_to_mm_wide_fifo #(.DATA_WIDTH(64), .DEPTH(16), .BACKPRESSURE(0)) dut_dr (
    .wrclock                    (clk),
    .reset                      (reset),
    .avalonst_sink_data         (s_data[1]),
    .avalonst_sink_valid        (s_valid[1]),
    .avalonst_sink_ready        (s_ready[1]),
    .avalonmm_slave_address     (addr[1]),
    .avalonmm_slave_read        (rd[1]),
    .avalonmm_slave_write       (wr[1]),
    .avalonmm_slave_writedata   (wd[1]),
    .avalonmm_slave_readdata    (rdata[1]),
    .avalonmm_slave_waitrequest (wreq[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [63:0] mq [2][$];
  logic        m_ovf  [2];
  logic [31:0] m_drop [2];
  logic [31:0] m_hi   [2];
  logic        m_rdy  [2];

  // At each falling edge: compare DUT outputs with the model, then advance the
  // model with the inputs that the next rising edge will sample.
  initial begin : model
    int          sz;
    logic        pop, push, drop, flush, clr, e_wreq, e_rdy;
    logic [63:0] head;
    logic [31:0] e_rd;
    string       tag;
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      m_ovf[i] = 1'b0; m_drop[i] = '0; m_hi[i] = '0; m_rdy[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        tag    = (i == 0) ? "bp" : "dr";
        sz     = mq[i].size();
        head   = (sz > 0) ? mq[i][0] : 64'd0;
        e_wreq = rd[i] && addr[i] == 2'd0 && sz == 0;
        e_rdy  = (i == 0) ? m_rdy[i] : !reset;
        e_rd   = '0;
        if (rd[i]) begin
          case (addr[i])
            2'd0:    e_rd = (sz > 0) ? head[31:0] : 32'd0;
            2'd1:    e_rd = m_hi[i];
            2'd2:    e_rd = {13'd0, m_ovf[i], sz == DEPTH, sz == 0, 16'(sz)};
            default: e_rd = m_drop[i];
          endcase
        end
        check({tag, ".model_ready"}, 32'(s_ready[i]), 32'(e_rdy));
        check({tag, ".model_waitrequest"}, 32'(wreq[i]), 32'(e_wreq));
        check({tag, ".model_readdata"}, rdata[i], e_rd);

        if (reset) begin
          mq[i].delete();
          m_ovf[i] = 1'b0; m_drop[i] = '0; m_hi[i] = '0; m_rdy[i] = 1'b0;
        end else begin
          pop   = rd[i] && addr[i] == 2'd0 && sz > 0;
          flush = wr[i] && addr[i] == 2'd3 && wd[i][0];
          clr   = wr[i] && addr[i] == 2'd3 && wd[i][1];
          if (i == 0) begin
            push = s_valid[i] && m_rdy[i];
            drop = 1'b0;
          end else begin
            push = s_valid[i] && (sz < DEPTH || pop);
            drop = s_valid[i] && !(sz < DEPTH || pop);
          end
          if (pop) begin
            m_hi[i] = head[63:32];
            void'(mq[i].pop_front());
          end
          if (flush) mq[i].delete();
          else if (push) mq[i].push_back(s_data[i]);
          if (clr) begin
            m_ovf[i] = 1'b0; m_drop[i] = '0;
          end else if (drop) begin
            m_ovf[i] = 1'b1;
            if (m_drop[i] != 32'hFFFF_FFFF) m_drop[i] = m_drop[i] + 32'd1;
          end
          m_rdy[i] = mq[i].size() < DEPTH;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  // All tasks start and end just after a rising edge.
  task automatic push_s(input int i, input logic [63:0] d);
    s_data[i] = d; s_valid[i] = 1'b1;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (s_ready[i]) break;
    end
    if (!s_ready[i]) check("push_ready_timeout", 32'(s_ready[i]), 32'd1);
    @(posedge clk); #1;
    s_valid[i] = 1'b0;
  endtask

  task automatic mm_read(input int i, input logic [1:0] a, input logic [31:0] exp, input string name);
    rd[i] = 1'b1; addr[i] = a;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (!wreq[i]) break;
    end
    if (wreq[i]) check({name, "_wait_timeout"}, 32'(wreq[i]), 32'd0);
    check(name, rdata[i], exp);
    @(posedge clk); #1;
    rd[i] = 1'b0;
  endtask

  task automatic mm_write(input int i, input logic [1:0] a, input logic [31:0] d);
    wr[i] = 1'b1; addr[i] = a; wd[i] = d;
    @(posedge clk); #1;
    wr[i] = 1'b0; wd[i] = '0;
  endtask

  initial begin : stim
    int acc;
    int k;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_data[i] = '0; s_valid[i] = 1'b0; addr[i] = '0;
      rd[i] = 1'b0; wr[i] = 1'b0; wd[i] = '0;
    end

    // Reset and idle
    repeat (3) begin
      @(negedge clk);
      check("ready_during_reset", 32'(s_ready[0]), 32'd0);
    end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("drop_ready_after_reset", 32'(s_ready[1]), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("ready_after_reset", 32'(s_ready[0]), 32'd1);
    @(posedge clk); #1;
    mm_read(0, 2'd2, 32'h0001_0000, "status_idle");
    rd[0] = 1'b1; addr[0] = 2'd0;
    repeat (6) begin
      @(negedge clk);
      check("idle_read_stalls", 32'(wreq[0]), 32'd1);
    end
    @(posedge clk); #1 rd[0] = 1'b0;

    // 64-bit ordering and high-word latch
    push_s(0, 64'h1111_2222_3333_4444);
    push_s(0, 64'hAAAA_BBBB_CCCC_DDDD);
    mm_read(0, 2'd0, 32'h3333_4444, "first_lo");
    mm_read(0, 2'd1, 32'h1111_2222, "first_hi");
    mm_read(0, 2'd0, 32'hCCCC_DDDD, "second_lo");
    mm_read(0, 2'd1, 32'hAAAA_BBBB, "second_hi");
    mm_read(0, 2'd2, 32'h0001_0000, "status_after_pairs");

    // Fill with backpressure
    acc = 0;
    s_valid[0] = 1'b1;
    for (int n = 0; n < 20; n++) begin
      s_data[0] = 64'h100 + 64'(n);
      @(negedge clk);
      if (s_ready[0]) acc++;
      @(posedge clk); #1;
    end
    s_valid[0] = 1'b0;
    check("fill_accepted", 32'(acc), 32'd16);
    @(negedge clk);
    check("fill_ready_low", 32'(s_ready[0]), 32'd0);
    @(posedge clk); #1;
    mm_read(0, 2'd2, 32'h0002_0010, "status_full");
    mm_read(0, 2'd0, 32'h0000_0100, "fill_pop");
    @(negedge clk);
    check("ready_after_pop", 32'(s_ready[0]), 32'd1);
    @(posedge clk); #1;
    push_s(0, 64'h777);
    mm_read(0, 2'd2, 32'h0002_0010, "status_refull");
    mm_write(0, 2'd3, 32'h1);
    mm_read(0, 2'd2, 32'h0001_0000, "status_after_flush");

    // Drop-on-full mode
    s_valid[1] = 1'b1;
    for (int n = 0; n < 20; n++) begin
      s_data[1] = 64'h1000 + 64'(n);
      @(posedge clk); #1;
    end
    s_valid[1] = 1'b0;
    mm_read(1, 2'd3, 32'd4, "drop_count");
    mm_read(1, 2'd2, 32'h0006_0010, "drop_status");
    mm_write(1, 2'd3, 32'h2);
    mm_read(1, 2'd3, 32'd0, "drop_count_cleared");
    mm_read(1, 2'd2, 32'h0002_0010, "drop_status_cleared");
    s_valid[1] = 1'b1; s_data[1] = 64'hBEEF;
    rd[1] = 1'b1; addr[1] = 2'd0;
    @(negedge clk);
    check("full_pushpop_data", rdata[1], 32'h0000_1000);
    @(posedge clk); #1;
    s_valid[1] = 1'b0; rd[1] = 1'b0;
    mm_read(1, 2'd3, 32'd0, "full_pushpop_no_drop");
    mm_read(1, 2'd2, 32'h0002_0010, "full_pushpop_level");

    // Flush collision
    mm_write(1, 2'd3, 32'h1);
    for (int n = 0; n < 5; n++) push_s(1, 64'h50 + 64'(n));
    mm_read(1, 2'd2, 32'h0000_0005, "status_level5");
    s_valid[1] = 1'b1; s_data[1] = 64'h99;
    wr[1] = 1'b1; addr[1] = 2'd3; wd[1] = 32'h1;
    @(posedge clk); #1;
    s_valid[1] = 1'b0; wr[1] = 1'b0; wd[1] = '0;
    mm_read(1, 2'd2, 32'h0001_0000, "status_flush_collision");
    rd[1] = 1'b1; addr[1] = 2'd0;
    repeat (3) begin
      @(negedge clk);
      check("flush_read_stalls", 32'(wreq[1]), 32'd1);
    end
    @(posedge clk); #1 rd[1] = 1'b0;

    // Stalled read released by a later push
    rd[0] = 1'b1; addr[0] = 2'd0;
    repeat (7) begin
      @(negedge clk);
      check("stall_before_push", 32'(wreq[0]), 32'd1);
      @(posedge clk); #1;
    end
    s_data[0] = 64'h5; s_valid[0] = 1'b1;
    @(posedge clk); #1;
    s_valid[0] = 1'b0;
    @(negedge clk);
    check("stall_release_wait", 32'(wreq[0]), 32'd0);
    check("stall_release_data", rdata[0], 32'h5);
    @(posedge clk); #1 rd[0] = 1'b0;

    // Stream 100 samples in batches of five to wrap the pointers
    for (int b = 0; b < 20; b++) begin
      for (int j = 0; j < 5; j++) begin
        k = b * 5 + j;
        push_s(0, {32'(k * 7), 32'h2000 + 32'(k)});
      end
      for (int j = 0; j < 5; j++) begin
        k = b * 5 + j;
        mm_read(0, 2'd0, 32'h2000 + 32'(k), "stream_lo");
        mm_read(0, 2'd1, 32'(k * 7), "stream_hi");
      end
    end
    mm_read(0, 2'd2, 32'h0001_0000, "stream_final_status");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
